// File: rtl/clarvi_fetch.sv
// Clarvi instruction fetch: pipelined Avalon-MM initiator, in-order fetch queue, redirect/discard handling.
// Optional misaligned-redirect trap output enabled by defining FETCH_MISALIGN_TRAP_EN.
module clarvi_fetch #(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned BUFFER_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] instr_address,
    output logic                  instr_read_enable,
    input  logic                  instr_wait,
    input  logic [31:0]           instr_read_data,
    input  logic                  instr_read_data_valid,
    input  logic                  redirect,
    input  logic [63:0]           redirect_pc,
    input  logic                  stall_stage,
    output logic [31:0]           out_instr,
    output logic [63:0]           out_pc,
    output logic                  out_valid
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                  out_misaligned
`endif
);

    localparam int unsigned PW = $clog2(BUFFER_DEPTH);
    localparam int unsigned CW = $clog2(BUFFER_DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    logic [63:0]           r_fetch_pc;
    logic [63:0]           r_resp_pc;
    logic [ADDR_WIDTH-1:0] r_stale_addr;
    logic                  r_hold;
    logic                  r_stale;
    logic                  r_idle;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_discard;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [31:0]           r_q_instr [BUFFER_DEPTH];
    logic [63:0]           r_q_pc    [BUFFER_DEPTH];
`ifdef FETCH_MISALIGN_TRAP_EN
    logic                  r_q_mis   [BUFFER_DEPTH];
`endif

    logic [63:0]   w_redirect_pc;
    logic          w_misaligned;
    logic          w_pop;
    logic [OW-1:0] w_occ;
    logic          w_accept;
    logic          w_held_next;
    logic          w_drop;
    logic          w_push;
    logic [CW-1:0] w_out_next;
    logic [CW-1:0] w_discard_set;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_redirect_pc = redirect_pc;
    assign w_misaligned  = |redirect_pc[1:0];
`else
    assign w_redirect_pc = redirect_pc & ~64'h3;
    assign w_misaligned  = 1'b0;
`endif

    assign out_valid = (r_count != '0);
    assign out_instr = r_q_instr[r_head];
    assign out_pc    = r_q_pc[r_head];
`ifdef FETCH_MISALIGN_TRAP_EN
    assign out_misaligned = out_valid & r_q_mis[r_head];
`endif

    // Credit counts this cycle's pop so a full stream can run at one word per cycle.
    assign w_pop = out_valid & ~stall_stage;
    assign w_occ = OW'(r_outstanding) + OW'(r_count) - OW'(w_pop);

    assign instr_read_enable = ~reset & (r_hold | (~r_idle & (w_occ < OW'(BUFFER_DEPTH))));
    assign instr_address     = r_stale ? r_stale_addr : r_fetch_pc[ADDR_WIDTH+1:2];

    assign w_accept      = instr_read_enable & ~instr_wait;
    assign w_held_next   = instr_read_enable & instr_wait;
    assign w_drop        = instr_read_data_valid & (r_discard != '0);
    assign w_push        = instr_read_data_valid & ~w_drop & ~redirect;
    assign w_out_next    = r_outstanding + CW'(w_accept) - CW'(instr_read_data_valid);
    assign w_discard_set = w_out_next + CW'(w_held_next);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_stale_addr  <= '0;
            r_hold        <= 1'b0;
            r_stale       <= 1'b0;
            r_idle        <= 1'b0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
        end else begin
            assert (!(w_push && (r_count == CW'(BUFFER_DEPTH))));
            assert (w_out_next <= CW'(BUFFER_DEPTH));
            assert (!redirect || (w_discard_set <= CW'(BUFFER_DEPTH)));

            r_outstanding <= w_out_next;
            r_hold        <= w_held_next;

            // A request still held across a redirect keeps its old address and becomes stale.
            if (w_accept) begin
                r_stale <= 1'b0;
            end else if (redirect && w_held_next) begin
                r_stale      <= 1'b1;
                r_stale_addr <= instr_address;
            end

            if (redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_discard  <= w_discard_set;
                r_idle     <= w_misaligned;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (w_misaligned) begin
                    r_tail  <= PW'(1);
                    r_count <= CW'(1);
                end
`endif
            end else begin
                if (w_accept && !r_stale)
                    r_fetch_pc <= r_fetch_pc + 64'd4;
                if (w_drop)
                    r_discard <= r_discard - CW'(1);
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 64'd4;
                    r_tail    <= r_tail + PW'(1);
                end
                if (w_pop)
                    r_head <= r_head + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_instr[r_tail] <= instr_read_data;
            r_q_pc[r_tail]    <= r_resp_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_q_mis[r_tail]   <= 1'b0;
`endif
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect && w_misaligned) begin
            r_q_instr[0] <= '0;
            r_q_pc[0]    <= redirect_pc;
            r_q_mis[0]   <= 1'b1;
        end
`endif
    end

endmodule

// File: doc/clarvi_fetch.md
Name: clarvi_fetch

Overview:
Instruction fetch stage for the Clarvi pipeline. It is the initiator on the instruction memory interface, driving pipelined Avalon-MM reads with waitrequest and readdatavalid. It buffers returned words in a small in-order queue and presents {instruction, pc} to decode. It also handles decode backpressure and redirects from branches and traps, including discarding responses that arrive after a redirect.

Parameters:
RESET_PC, 64'h0, pc fetched first after reset (must be 4-byte aligned)
ADDR_WIDTH, 16, word-address width on the instruction bus
BUFFER_DEPTH, 2, entries in the fetch queue; also the cap on in-flight plus buffered words (power of two, at least 2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
instr_address  out  ADDR_WIDTH  word address, equal to fetch_pc[ADDR_WIDTH+1:2]
instr_read_enable  out  1  Avalon read request
instr_wait  in  1  Avalon waitrequest
instr_read_data  in  32  returned instruction word
instr_read_data_valid  in  1  Avalon readdatavalid
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  64  new fetch pc
stall_stage  in  1  decode not accepting this cycle
out_instr  out  32  instruction to decode (in_instr)
out_pc  out  64  pc of out_instr (if_de_pc)
out_valid  out  1  out_instr and out_pc are valid (the inverse of the decode stage_invalid input)

Behaviour:
- Reset state: out_valid=0, instr_read_enable=0, queue empty, outstanding=0, discard=0, fetch_pc=RESET_PC. out_instr and out_pc are don't-care while out_valid=0.
- Request issue: the block asserts a read when there is no pending request and outstanding+occupancy < BUFFER_DEPTH. Earliest issue is the first cycle after reset deasserts.
- A request is accepted in a cycle where instr_read_enable=1 and instr_wait=0.
  - On acceptance: outstanding+1; fetch_pc += 4, wrapping modulo 2^64.
  - While instr_wait=1, instr_read_enable and instr_address stay stable.
- Back-to-back requests are allowed: one accept per cycle with zero wait.
- Response handling: on instr_read_data_valid, outstanding-1.
  - If discard>0, discard-1 and the word is dropped.
  - Otherwise the word is pushed to the queue with its pc. pcs are tracked in issue order; responses are always in order.
- Output:
  - The queue head drives out_instr and out_pc.
  - out_valid is high when the queue is non-empty.
  - Pop when out_valid && !stall_stage. Push and pop in the same cycle keep occupancy unchanged.
  - Registered path: readdatavalid in cycle N gives out_valid in cycle N+1 at the earliest.
- Full queue: the credit rule guarantees there is never a push into a full queue. An implementation assertion checks this.
- Redirect (highest priority):
  - The queue is flushed in the same cycle, so out_valid=0 next cycle, and any pop that cycle is ignored.
  - fetch_pc takes redirect_pc.
  - discard is set to outstanding (counted after this cycle's accept and response) plus 1 if a request is still held by instr_wait.
  - A held request is kept asserted with its old address until accepted. It is counted as stale and its pc is not advanced. The new-address request issues after that.
  - Back-to-back redirects: the last one wins, and discards accumulate.
- Counters: outstanding and discard saturate-check at BUFFER_DEPTH; overflow is an assertion failure.
- Reset mid-operation returns to the reset state in one cycle. The bus is assumed reset by the same signal, so there are no stale responses after reset.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined: adds output out_misaligned (1 bit).
  - If redirect_pc[1:0] != 0, no reads issue.
  - One entry is produced with out_valid=1, out_misaligned=1, out_pc=redirect_pc, out_instr=32'h0.
  - Fetch then idles until the next redirect.
- Undefined: redirect_pc[1:0] is ignored (forced to 0); there is no out_misaligned port.

Test Plan:
- Reset release, RESET_PC=0x100, zero-wait memory returning data one cycle after accept -> reads at word 0x40, 0x41, ...; out_pc sequence 0x100, 0x104, 0x108; out_valid continuous from cycle 3.
- instr_wait held high 3 cycles on first request -> instr_address constant at 0x40 for 4 cycles; exactly one outstanding read; single response accepted.
- stall_stage held high 5 cycles -> at most BUFFER_DEPTH=2 words queued plus in flight; no further requests; out_instr/out_pc unchanged; stream resumes in order on release.
- redirect to 0x200 with 2 reads outstanding -> the next 2 responses are dropped; first out_pc=0x200; no out_valid from the old path after the redirect cycle.
- redirect while request held by instr_wait at word 0x45 -> word 0x45 still issued and discarded, then a request to 0x80; out_pc=0x200.
- Feature on: redirect to 0x202 -> no bus reads; one output with out_misaligned=1, out_pc=0x202; idle until the next redirect.
